// File: rtl/snn_pkg.sv
// snn_pkg: shared FSM state, record layout and saturation helper for the spike train decoder.
package snn_pkg;

    localparam int SPIKE_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW
    } spike_dec_state_t;

    typedef struct packed {
        logic                   sat;
        logic [SPIKE_CNT_W-1:0] gap;
        logic [SPIKE_CNT_W-1:0] width;
    } spike_rec_t;

    // Largest value representable in a w-bit counter (w <= 32).
    function automatic logic [31:0] sat_max(input int w);
        return 32'((64'd1 << w) - 64'd1);
    endfunction

endpackage

// File: rtl/spike_rec_fifo.sv
// spike_rec_fifo: synchronous record FIFO with full/empty flags; a push while full is
// accepted when a pop happens in the same cycle.
module spike_rec_fifo
    import snn_pkg::*;
#(
    parameter type rec_t = spike_rec_t,
    parameter int  DEPTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic push,
    input  logic pop,
    input  rec_t din,
    output rec_t dout,
    output logic full,
    output logic empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_q;
    logic [AW:0] rd_q;
    logic        do_push;
    logic        do_pop;
    rec_t        mem [DEPTH];

    assign empty   = wr_q == rd_q;
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else if (clear) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= do_push ? wr_q + 1'b1 : wr_q;
            rd_q <= do_pop ? rd_q + 1'b1 : rd_q;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/spike_train_decoder.sv
// spike_train_decoder: turns a sampled spike train into {width, gap, sat} records in a FIFO.
// Define SPIKE_DEC_SYNC_EN to pass spike_in through a 2-flop synchroniser first.
module spike_train_decoder
    import snn_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             spike_in,
    input  logic             en,
    input  logic             clear,
    output logic             rec_valid,
    input  logic             rec_ready,
    output logic [CNT_W-1:0] rec_width,
    output logic [CNT_W-1:0] rec_gap,
    output logic             rec_sat,
    output logic [CNT_W-1:0] spike_count,
    output logic             overflow
);
    typedef struct packed {
        logic             sat;
        logic [CNT_W-1:0] gap;
        logic [CNT_W-1:0] width;
    } dec_rec_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sat_max(CNT_W));

    spike_dec_state_t state_q, state_d;
    logic [CNT_W-1:0] width_q, width_d;
    logic [CNT_W-1:0] gap_q, gap_d;
    logic             first_q, first_d;
    logic             spike_s;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic [CNT_W-1:0] gap_rec;
    dec_rec_t         rec_in;
    dec_rec_t         head;

`ifdef SPIKE_DEC_SYNC_EN
    logic [1:0] sync_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sync_q <= '0;
        else sync_q <= {sync_q[0], spike_in};
    end
    assign spike_s = sync_q[1];
`else
    assign spike_s = spike_in;
`endif

    always_comb begin
        state_d = state_q;
        width_d = width_q;
        gap_d   = gap_q;
        first_d = first_q;
        push    = 1'b0;
        if (!en) begin
            state_d = IDLE;
            width_d = '0;
            gap_d   = '0;
            first_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    gap_d   = '0;
                    width_d = spike_s ? CNT_W'(1) : '0;
                    first_d = spike_s;
                    state_d = spike_s ? HIGH : IDLE;
                end
                HIGH: begin
                    if (spike_s) begin
                        width_d = (width_q == CNT_MAX) ? width_q : width_q + CNT_W'(1);
                    end else begin
                        push    = 1'b1;
                        gap_d   = CNT_W'(1);
                        first_d = 1'b0;
                        state_d = LOW;
                    end
                end
                LOW: begin
                    if (spike_s) begin
                        width_d = CNT_W'(1);
                        state_d = HIGH;
                    end else begin
                        gap_d = (gap_q == CNT_MAX) ? gap_q : gap_q + CNT_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // The first pulse of a session has no preceding gap to report.
    assign gap_rec = first_q ? '0 : gap_q;
    assign rec_in  = '{sat: (width_q == CNT_MAX) || (gap_rec == CNT_MAX), gap: gap_rec, width: width_q};
    assign pop     = rec_valid & rec_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            width_q     <= '0;
            gap_q       <= '0;
            first_q     <= 1'b0;
            spike_count <= '0;
            overflow    <= 1'b0;
        end else begin
            state_q     <= state_d;
            width_q     <= width_d;
            gap_q       <= gap_d;
            first_q     <= first_d;
            spike_count <= clear ? '0 :
                           (push && spike_count != CNT_MAX) ? spike_count + CNT_W'(1) : spike_count;
            overflow    <= clear ? 1'b0 : overflow | (push & full & ~pop);
        end
    end

    spike_rec_fifo #(
        .rec_t(dec_rec_t),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .clear(clear),
        .push (push & ~clear),
        .pop  (pop),
        .din  (rec_in),
        .dout (head),
        .full (full),
        .empty(empty)
    );

    assign rec_valid = ~empty;
    assign rec_width = rec_valid ? head.width : '0;
    assign rec_gap   = rec_valid ? head.gap : '0;
    assign rec_sat   = rec_valid & head.sat;

endmodule

// File: tb/tb_spike_train_decoder.sv
// tb_spike_train_decoder: table-driven and random checks of the decoder against a run-length model.
module tb_spike_train_decoder;

    localparam int W     = 16;
    localparam int DEPTH = 8;
    localparam int MAX   = 65535;
`ifdef SPIKE_DEC_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif
    localparam int PAD = LAT + 2;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         spike_in = 1'b0;
    logic         en = 1'b0;
    logic         clear = 1'b0;
    logic         rec_ready = 1'b0;
    logic         rec_valid, rec_sat, overflow;
    logic [W-1:0] rec_width, rec_gap, spike_count;
    logic         rec_valid4, rec_sat4, overflow4;
    logic [3:0]   rec_width4, rec_gap4, spike_count4;

    spike_train_decoder #(.CNT_W(W), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .spike_in(spike_in), .en(en), .clear(clear),
        .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_width(rec_width), .rec_gap(rec_gap),
        .rec_sat(rec_sat), .spike_count(spike_count), .overflow(overflow)
    );

    spike_train_decoder #(.CNT_W(4), .FIFO_DEPTH(DEPTH)) dut4 (
        .clk(clk), .rst(rst), .spike_in(spike_in), .en(en), .clear(clear),
        .rec_valid(rec_valid4), .rec_ready(rec_ready), .rec_width(rec_width4), .rec_gap(rec_gap4),
        .rec_sat(rec_sat4), .spike_count(spike_count4), .overflow(overflow4)
    );

    always #5 clk = ~clk;

    typedef struct {
        int width;
        int gap;
        bit sat;
    } rec_m_t;

    typedef struct {
        int hi;
        int lo;
        int w;
        int g;
    } vec_t;

    int     errors = 0;
    int     checks = 0;
    rec_m_t exp_q[$];
    bit     hist[$];
    bit     dly[$];
    int     exp_cnt = 0;
    bit     exp_ovf = 1'b0;
    vec_t   tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        hist.delete();
        dly.delete();
        for (int i = 0; i < LAT; i++) dly.push_back(1'b0);
        exp_cnt = 0;
        exp_ovf = 1'b0;
    endtask

    // Records come from run lengths of the samples seen since decoding was last enabled.
    task automatic model_edge();
        bit     eff;
        bit     pop;
        bit     push;
        int     i;
        rec_m_t r;
        r    = '{0, 0, 1'b0};
        push = 1'b0;
        pop  = rec_ready && exp_q.size() > 0;
        dly.push_back(spike_in);
        eff = dly.pop_front();
        if (!en) hist.delete();
        else begin
            hist.push_back(eff);
            if (hist.size() >= 2 && hist[hist.size()-2] && !hist[hist.size()-1]) begin
                push = 1'b1;
                i = hist.size() - 2;
                while (i >= 0 && hist[i]) begin r.width++; i--; end
                while (i >= 0 && !hist[i]) begin r.gap++; i--; end
                if (i < 0) r.gap = 0;
                r.sat = (r.width >= MAX) || (r.gap >= MAX);
                if (r.width > MAX) r.width = MAX;
                if (r.gap > MAX) r.gap = MAX;
            end
        end
        if (clear) begin
            exp_q.delete();
            exp_ovf = 1'b0;
            exp_cnt = 0;
        end else begin
            if (pop) exp_q.delete(0);
            if (push) begin
                if (exp_q.size() < DEPTH) exp_q.push_back(r);
                else exp_ovf = 1'b1;
                if (exp_cnt < MAX) exp_cnt++;
            end
        end
    endtask

    task automatic check_all();
        rec_m_t h;
        h = '{0, 0, 1'b0};
        if (exp_q.size() > 0) h = exp_q[0];
        chk("rec_valid", rec_valid, exp_q.size() > 0);
        chk("rec_width", rec_width, h.width);
        chk("rec_gap", rec_gap, h.gap);
        chk("rec_sat", rec_sat, h.sat);
        chk("spike_count", spike_count, exp_cnt);
        chk("overflow", overflow, exp_ovf);
    endtask

    task automatic step(input logic s, input logic e = 1'b1, input logic r = 1'b1, input logic c = 1'b0);
        spike_in  = s;
        en        = e;
        rec_ready = r;
        clear     = c;
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic pop_chk(input string name, input int w, input int g, input bit s);
        chk({name, " valid"}, rec_valid, 1);
        chk({name, " width"}, rec_width, w);
        if (g >= 0) chk({name, " gap"}, rec_gap, g);
        chk({name, " sat"}, rec_sat, s);
        step(0, 1, 1);
    endtask

    initial begin
        tbl[0] = '{1, 1, 1, 0};
        tbl[1] = '{1, 1, 1, 1};
        tbl[2] = '{1, 1, 1, 1};
        for (int i = 1; i <= 5; i++) tbl[2+i] = '{i, i, i, i - 1};

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset valid", rec_valid, 0);
        chk("reset width", rec_width, 0);
        chk("reset gap", rec_gap, 0);
        chk("reset sat", rec_sat, 0);
        chk("reset count", spike_count, 0);
        chk("reset overflow", overflow, 0);
        rst = 1'b1;

        // Three 1-high/1-low pulses.
        step(0, 1, 0);
        for (int k = 0; k < 3; k++) begin
            repeat (tbl[k].hi) step(1, 1, 0);
            repeat (tbl[k].lo) step(0, 1, 0);
        end
        repeat (PAD) step(0, 1, 0);
        chk("groupA count", spike_count, 3);
        for (int k = 0; k < 3; k++) pop_chk("groupA", tbl[k].w, tbl[k].g, 0);
        chk("groupA drained", rec_valid, 0);

        // Increasing train after a return to IDLE.
        step(0, 0, 0);
        for (int k = 3; k < 8; k++) begin
            repeat (tbl[k].hi) step(1, 1, 0);
            repeat (tbl[k].lo) step(0, 1, 0);
        end
        repeat (PAD) step(0, 1, 0);
        chk("groupB count", spike_count, 8);
        for (int k = 3; k < 8; k++) pop_chk("groupB", tbl[k].w, tbl[k].g, 0);

        // Overflow with the reader stalled, then clear.
        step(0, 1, 1, 1);
        chk("clear count", spike_count, 0);
        repeat (10) begin
            step(1, 1, 0);
            step(0, 1, 0);
        end
        repeat (PAD) step(0, 1, 0);
        chk("ovf flag", overflow, 1);
        chk("ovf count", spike_count, 10);
        for (int k = 0; k < DEPTH; k++) pop_chk("ovf rec", 1, -1, 0);
        chk("ovf retained", rec_valid, 0);
        chk("ovf sticky", overflow, 1);
        step(0, 1, 1, 1);
        chk("clear overflow", overflow, 0);
        chk("clear valid", rec_valid, 0);

        // Saturation in the narrow instance.
        step(0, 0, 0);
        repeat (20) step(1, 1, 0);
        repeat (PAD) step(0, 1, 0);
        chk("sat4 valid", rec_valid4, 1);
        chk("sat4 width", rec_width4, 15);
        chk("sat4 sat", rec_sat4, 1);
        chk("sat4 count", spike_count4, 1);
        chk("wide width", rec_width, 20);
        chk("wide sat", rec_sat, 0);
        step(0, 1, 1);

        // Enable dropped mid-pulse.
        step(0, 0, 1);
        step(0, 1, 1);
        repeat (3) step(1, 1, 1);
        repeat (PAD) step(0, 0, 1);
        chk("en drop no rec", rec_valid, 0);
        chk("en drop count", spike_count, 1);
        repeat (2) step(0, 1, 0);
        repeat (2) step(1, 1, 0);
        repeat (PAD) step(0, 1, 0);
        pop_chk("after en drop", 2, 0, 0);

        // Reset asserted mid-pulse.
        repeat (3) step(1, 1, 0);
        rst = 1'b0;
        spike_in = 1'b0;
        #1;
        model_reset();
        check_all();
        repeat (2) @(posedge clk);
        #1;
        chk("rst hold valid", rec_valid, 0);
        rst = 1'b1;
        repeat (2) step(0, 1, 0);
        repeat (2) step(1, 1, 0);
        repeat (PAD) step(0, 1, 0);
        chk("after rst count", spike_count, 1);
        pop_chk("after rst", 2, 0, 0);

        // Full FIFO with simultaneous push and pop.
        step(0, 1, 0, 1);
        for (int w = 1; w <= DEPTH; w++) begin
            repeat (w) step(1, 1, 0);
            step(0, 1, 0);
        end
        repeat (PAD) step(0, 1, 0);
        repeat (3) step(1, 1, 0);
        repeat (LAT) step(0, 1, 0);
        step(0, 1, 1);
        chk("full pushpop ovf", overflow, 0);
        chk("full pushpop count", spike_count, DEPTH + 1);
        for (int w = 2; w <= DEPTH; w++) pop_chk("order", w, -1, 0);
        pop_chk("order last", 3, -1, 0);
        chk("order drained", rec_valid, 0);

        // Random traffic against the model.
        begin
            bit lvl;
            int run;
            lvl = 1'b0;
            run = 0;
            for (int n = 0; n < 1500; n++) begin
                if (run == 0) begin
                    lvl = ~lvl;
                    run = $urandom_range(1, 6);
                end
                run--;
                step(lvl, $urandom_range(0, 49) != 0, $urandom_range(0, 1), $urandom_range(0, 99) == 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spike_train_decoder.md
# spike_train_decoder

Receive-side companion to the SNN spike stimulus path: samples the single-bit `spike_out` train produced by `snn_fpga_top`, decodes each spike into a record of high-pulse width and preceding low gap (in clock cycles), and buffers the records in a small FIFO. Records are drained over a valid/ready interface by a host-side reader or a scoreboard. It lets the FPGA characterise neuron output timing in hardware instead of relying on a simulation-only monitor.

## Interface
- `CNT_W`, 16: width of the width, gap and total-count counters
- `FIFO_DEPTH`, 8: record FIFO entries; must be a power of 2, ≥2
- `clk`  in  1: single clock, all logic rising-edge
- `rst`  in  1: asynchronous, active-low reset (asserted when 0)
- `spike_in`  in  1: spike train, synchronous to `clk` unless synchroniser is compiled in
- `en`  in  1: decode enable; when 0, the FSM holds in IDLE and counters stay cleared
- `clear`  in  1: synchronous one-cycle clear of FIFO, `overflow` and `spike_count`
- `rec_valid`  out  1: FIFO non-empty
- `rec_ready`  in  1: consumer accepts the head record when `rec_valid & rec_ready`
- `rec_width`  out  CNT_W: high-pulse length of the head record
- `rec_gap`  out  CNT_W: low cycles before that pulse; 0 for the first pulse after IDLE
- `rec_sat`  out  1: width or gap saturated in the head record
- `spike_count`  out  CNT_W: total completed pulses, saturating
- `overflow`  out  1: sticky flag; a record was dropped because the FIFO was full

## Operation
- FSM states: IDLE, HIGH, LOW.
- IDLE: `gap_cnt` = 0. Sampled `spike_in`=1 → HIGH with `width_cnt`=1 and `first`=1.
- HIGH: `spike_in`=1 → `width_cnt`++. `spike_in`=0 → push record {width_cnt, first ? 0 : gap_cnt, sat}, `spike_count`++, `gap_cnt`=1, `first`=0, go to LOW.
- LOW: `spike_in`=0 → `gap_cnt`++. `spike_in`=1 → HIGH with `width_cnt`=1.
- `en`=0 in any state → IDLE next cycle. A pulse in progress is discarded with no record.
- Counters saturate at 2^CNT_W−1. `rec_sat` = either counter saturated. `spike_count` saturates silently.
- FIFO full on push: the record is dropped and `overflow` is set. A push and pop in the same cycle when full: pop is taken and push is accepted, so no drop.
- `clear` takes priority over a same-cycle push. It does not disturb the FSM state or in-progress counters.

## Timing
- Reset values: state IDLE, all counters 0, FIFO empty, `rec_valid`=0, `rec_width`=0, `rec_gap`=0, `rec_sat`=0, `spike_count`=0, `overflow`=0.
- A pulse is high in sample cycles N..N+k−1 and first samples low at N+k. The push happens at the N+k edge. `rec_valid` and the record appear at N+k+1.
- Pop: the head advances on the edge where `rec_valid & rec_ready`. Outputs show the next record, or `rec_valid`=0, one cycle later. Outputs are stable while `rec_valid & !rec_ready`.
- Minimum decodable pulse and gap: 1 cycle each.
- `rst` asserted mid-pulse: immediate return to reset values. No partial record is produced.

## Configuration
- `SPIKE_DEC_SYNC_EN` defined: `spike_in` passes through a 2-flop synchroniser (reset to 0) before the FSM. This adds exactly 2 cycles to every latency above and allows asynchronous sources.
- Not defined: `spike_in` is sampled directly. Latency is as stated under Timing.

## Structure
- Package `snn_pkg`: FSM state enum `spike_dec_state_t` (IDLE, HIGH, LOW), record struct `spike_rec_t` {sat, gap, width}, and the saturation constant helper.
- Sub-module `spike_rec_fifo`: synchronous FIFO of `spike_rec_t`, parameterised by depth, with full/empty flags and simultaneous push/pop.

## Test plan
- Reset, then 1-high/1-low pulses ×3 → records (1,0), (1,1), (1,1); `spike_count`=3.
- Increasing train: high i, low i cycles for i=1..5 → widths 1..5, gaps 0,1,2,3,4, each `rec_valid` 1 cycle after its falling edge.
- Hold `rec_ready`=0 and send 10 pulses with FIFO_DEPTH=8 → 8 records retained, `overflow`=1. Then `clear` → `rec_valid`=0, `overflow`=0.
- CNT_W=4 with a 20-cycle high pulse → `rec_width`=15, `rec_sat`=1.
- Drop `en` mid-pulse, and assert `rst` mid-pulse in a second run → no record, FSM in IDLE, the next pulse has gap 0.
- FIFO full with push and pop in the same cycle → no drop, `overflow` stays 0, order preserved.
